// File: rtl/scr1_bru_bpu_upd.sv
// -----------------------------------------------------------------------------
// scr1_bru_bpu_upd
//
// Branch resolution unit that feeds the BPU update stream. Every conditional
// branch resolved by the EXU is classified against the prediction the IFU
// attached to it:
//   - a registered one-cycle mispredict pulse plus the correct fetch PC goes
//     back to the EXU;
//   - one update record per branch is queued in a small FIFO and presented to
//     the BPU update port with a valid/ready handshake.
// Not-taken branches are queued as well, so the BPU trains on every
// resolution.
//
// Ports
//   clk, rst_n                 core clock, synchronous active-low reset
//   exu2bru_*                  resolved branch from EXU (vd/rdy handshake)
//   bru2exu_mispred_o          one-cycle pulse, 1 cycle after accept
//   bru2exu_redirect_pc_o      correct next PC, valid with the pulse
//   bru2bpu_upd_vd_o           head record valid (FIFO not empty)
//   bpu2bru_upd_rdy_i          BPU consumes the head record
//   bru2bpu_pc_prev_o ...      fields of the head record
//   bru_resolved_cnt_o         saturating count of accepted branches
//   bru_mispred_cnt_o          saturating count of mispredicts
// -----------------------------------------------------------------------------
module scr1_bru_bpu_upd #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,   // power of two, >= 2
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             exu2bru_vd_i,
    output logic             exu2bru_rdy_o,
    input  logic [XLEN-1:0]  exu2bru_pc_i,
    input  logic             exu2bru_rvi_i,
    input  logic             exu2bru_taken_i,
    input  logic [XLEN-1:0]  exu2bru_target_i,
    input  logic             exu2bru_pred_i,
    input  logic [XLEN-1:0]  exu2bru_pred_tgt_i,

    output logic             bru2exu_mispred_o,
    output logic [XLEN-1:0]  bru2exu_redirect_pc_o,

    output logic             bru2bpu_upd_vd_o,
    input  logic             bpu2bru_upd_rdy_i,
    output logic [XLEN-1:0]  bru2bpu_pc_prev_o,
    output logic [XLEN-1:0]  bru2bpu_pc_new_o,
    output logic             bru2bpu_prev_prediction_o,
    output logic             bru2bpu_btb_miss_o,
    output logic             bru2bpu_rvi_flag_o,

    output logic [CNT_W-1:0] bru_resolved_cnt_o,
    output logic [CNT_W-1:0] bru_mispred_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc_prev;
        logic [XLEN-1:0] pc_new;
        logic            pred;
        logic            btb_miss;
        logic            rvi;
    } upd_rec_t;

    // Classification of the incoming branch
    logic [XLEN-1:0] fallthrough_pc;
    logic [XLEN-1:0] next_pc;
    logic            btb_miss;
    logic            mispred;
    logic            accept;

    // FIFO state
    upd_rec_t        mem_q [DEPTH];
    upd_rec_t        head;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             full;
    logic             empty;
    logic             pop;

    // Redirect and counters
    logic             mispred_q;
    logic [XLEN-1:0]  redirect_q;
    logic [CNT_W-1:0] resolved_cnt_q;
    logic [CNT_W-1:0] mispred_cnt_q;

    // NOTE: every always_comb output gets a default/unconditional value first
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        fallthrough_pc = exu2bru_pc_i + (exu2bru_rvi_i ? XLEN'(4) : XLEN'(2));
        next_pc        = exu2bru_taken_i ? exu2bru_target_i : fallthrough_pc;
        btb_miss       = exu2bru_pred_i & exu2bru_taken_i
                       & (exu2bru_target_i != exu2bru_pred_tgt_i);
        mispred        = (exu2bru_taken_i != exu2bru_pred_i) | btb_miss;

        full   = (count_q == (PTR_W+1)'(DEPTH));
        empty  = (count_q == '0);
        accept = exu2bru_vd_i & ~full;
        pop    = ~empty & bpu2bru_upd_rdy_i;

        // Storage is not reset, so the head is forced to zero while empty to
        // keep the BPU-facing fields at their reset value.
        head = empty ? '0 : mem_q[rd_ptr_q];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mispred_q  <= 1'b0;
            redirect_q <= '0;
        end else begin
            mispred_q <= accept & mispred;
            // Redirect holds its last value when there is no mispredict.
            if (accept & mispred) begin
                redirect_q <= next_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            unique case ({accept, pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;   // idle, or push and pop together
            endcase
        end
    end

    // NOTE: the record storage has no reset; pointers and occupancy alone
    // decide what is valid, and the head is masked while empty.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= '{pc_prev:  exu2bru_pc_i,
                                 pc_new:   next_pc,
                                 pred:     exu2bru_pred_i,
                                 btb_miss: btb_miss,
                                 rvi:      exu2bru_rvi_i};
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resolved_cnt_q <= '0;
            mispred_cnt_q  <= '0;
        end else begin
            if (accept && (resolved_cnt_q != '1)) begin
                resolved_cnt_q <= resolved_cnt_q + CNT_W'(1);
            end
            if (accept && mispred && (mispred_cnt_q != '1)) begin
                mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
            end
        end
    end

    assign exu2bru_rdy_o             = ~full;
    assign bru2exu_mispred_o         = mispred_q;
    assign bru2exu_redirect_pc_o     = redirect_q;
    assign bru2bpu_upd_vd_o          = ~empty;
    assign bru2bpu_pc_prev_o         = head.pc_prev;
    assign bru2bpu_pc_new_o          = head.pc_new;
    assign bru2bpu_prev_prediction_o = head.pred;
    assign bru2bpu_btb_miss_o        = head.btb_miss;
    assign bru2bpu_rvi_flag_o        = head.rvi;
    assign bru_resolved_cnt_o        = resolved_cnt_q;
    assign bru_mispred_cnt_o         = mispred_cnt_q;

endmodule

// File: tb/tb_scr1_bru_bpu_upd.sv
// -----------------------------------------------------------------------------
// Testbench for scr1_bru_bpu_upd. Two instances share the same stimulus: the
// main one (CNT_W=16) and a narrow-counter one (CNT_W=2) for saturation.
// A negedge monitor keeps a queue of expected update records for the main
// instance; scenario tasks check the EXU-side and counter behaviour inline.
// Inputs change 1 time unit after posedge; outputs are sampled at negedge.
// -----------------------------------------------------------------------------
module tb_scr1_bru_bpu_upd;

    localparam int XLEN = 32;

    typedef struct {
        logic [XLEN-1:0] pc_prev;
        logic [XLEN-1:0] pc_new;
        logic            pred;
        logic            btb_miss;
        logic            rvi;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            vd, rvi, taken, pred, upd_rdy;
    logic [XLEN-1:0] pc, target, pred_tgt;

    logic            rdy, mispred, upd_vd, prev_pred, btb_miss_o, rvi_flag;
    logic [XLEN-1:0] redirect, pc_prev, pc_new;
    logic [15:0]     res_cnt, mis_cnt;

    logic            b_rdy, b_mispred, b_upd_vd, b_prev_pred, b_btb_miss, b_rvi_flag;
    logic [XLEN-1:0] b_redirect, b_pc_prev, b_pc_new;
    logic [1:0]      b_res_cnt, b_mis_cnt;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    scr1_bru_bpu_upd #(.XLEN(XLEN), .DEPTH(4), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .exu2bru_vd_i(vd), .exu2bru_rdy_o(rdy), .exu2bru_pc_i(pc),
        .exu2bru_rvi_i(rvi), .exu2bru_taken_i(taken), .exu2bru_target_i(target),
        .exu2bru_pred_i(pred), .exu2bru_pred_tgt_i(pred_tgt),
        .bru2exu_mispred_o(mispred), .bru2exu_redirect_pc_o(redirect),
        .bru2bpu_upd_vd_o(upd_vd), .bpu2bru_upd_rdy_i(upd_rdy),
        .bru2bpu_pc_prev_o(pc_prev), .bru2bpu_pc_new_o(pc_new),
        .bru2bpu_prev_prediction_o(prev_pred), .bru2bpu_btb_miss_o(btb_miss_o),
        .bru2bpu_rvi_flag_o(rvi_flag),
        .bru_resolved_cnt_o(res_cnt), .bru_mispred_cnt_o(mis_cnt)
    );

    scr1_bru_bpu_upd #(.XLEN(XLEN), .DEPTH(4), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .exu2bru_vd_i(vd), .exu2bru_rdy_o(b_rdy), .exu2bru_pc_i(pc),
        .exu2bru_rvi_i(rvi), .exu2bru_taken_i(taken), .exu2bru_target_i(target),
        .exu2bru_pred_i(pred), .exu2bru_pred_tgt_i(pred_tgt),
        .bru2exu_mispred_o(b_mispred), .bru2exu_redirect_pc_o(b_redirect),
        .bru2bpu_upd_vd_o(b_upd_vd), .bpu2bru_upd_rdy_i(upd_rdy),
        .bru2bpu_pc_prev_o(b_pc_prev), .bru2bpu_pc_new_o(b_pc_new),
        .bru2bpu_prev_prediction_o(b_prev_pred), .bru2bpu_btb_miss_o(b_btb_miss),
        .bru2bpu_rvi_flag_o(b_rvi_flag),
        .bru_resolved_cnt_o(b_res_cnt), .bru_mispred_cnt_o(b_mis_cnt)
    );

    // Scoreboard monitor: pop/compare the head on each BPU handshake, push the
    // expected record on each EXU handshake. A reset edge discards everything.
    always @(negedge clk) begin
        exp_t e;
        logic [XLEN-1:0] ft;
        if (rst_n !== 1'b1) begin
            sb.delete();
        end else begin
            n_cmp++;
            if (upd_vd !== (sb.size() != 0)) begin
                n_err++;
                $display("FAIL sb_upd_vd: got %b expected %b (queued %0d) at %0t",
                         upd_vd, sb.size() != 0, sb.size(), $time);
            end
            if (upd_vd === 1'b1 && upd_rdy === 1'b1 && sb.size() != 0) begin
                e = sb.pop_front();
                n_cmp++;
                if ({pc_prev, pc_new, prev_pred, btb_miss_o, rvi_flag} !==
                    {e.pc_prev, e.pc_new, e.pred, e.btb_miss, e.rvi}) begin
                    n_err++;
                    $display("FAIL sb_record: got pc_prev=%h pc_new=%h pred=%b btb=%b rvi=%b expected pc_prev=%h pc_new=%h pred=%b btb=%b rvi=%b",
                             pc_prev, pc_new, prev_pred, btb_miss_o, rvi_flag,
                             e.pc_prev, e.pc_new, e.pred, e.btb_miss, e.rvi);
                end
            end
            if (vd === 1'b1 && rdy === 1'b1) begin
                ft         = pc + (rvi ? 32'd4 : 32'd2);
                e.pc_prev  = pc;
                e.pc_new   = taken ? target : ft;
                e.pred     = pred;
                e.btb_miss = pred & taken & (target != pred_tgt);
                e.rvi      = rvi;
                sb.push_back(e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one branch and hold it until accepted (bounded); returns 1 unit
    // after the accepting edge with vd dropped.
    task automatic send(input logic [XLEN-1:0] p, input logic r, input logic t,
                        input logic [XLEN-1:0] tg, input logic pr,
                        input logic [XLEN-1:0] ptg);
        int w = 0;
        pc = p; rvi = r; taken = t; target = tg; pred = pr; pred_tgt = ptg;
        vd = 1'b1;
        @(negedge clk);
        while (rdy !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        n_cmp++;
        if (rdy !== 1'b1) begin
            n_err++;
            $display("FAIL send_timeout: rdy=%b expected 1 for pc=%h", rdy, p);
        end
        tick();
        vd = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (rdy !== 1'b1) begin n_err++; $display("FAIL reset_rdy: got %b expected 1", rdy); end
        n_cmp++;
        if ({mispred, redirect} !== 33'd0) begin
            n_err++; $display("FAIL reset_redirect: got mispred=%b redirect=%h expected 0", mispred, redirect);
        end
        n_cmp++;
        if ({upd_vd, pc_prev, pc_new, prev_pred, btb_miss_o, rvi_flag} !== '0) begin
            n_err++; $display("FAIL reset_upd: got vd=%b pc_prev=%h pc_new=%h expected all 0", upd_vd, pc_prev, pc_new);
        end
        n_cmp++;
        if (res_cnt !== 16'd0 || mis_cnt !== 16'd0) begin
            n_err++; $display("FAIL reset_cnt: got res=%0d mis=%0d expected 0", res_cnt, mis_cnt);
        end
        tick();
    endtask

    task automatic test_not_taken();
        send(32'h100, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        n_cmp++;
        if (mispred !== 1'b0) begin n_err++; $display("FAIL nt_mispred: got %b expected 0", mispred); end
        n_cmp++;
        if (upd_vd !== 1'b1 || pc_prev !== 32'h100 || pc_new !== 32'h104) begin
            n_err++; $display("FAIL nt_upd: got vd=%b pc_prev=%h pc_new=%h expected 1/100/104", upd_vd, pc_prev, pc_new);
        end
        n_cmp++;
        if (prev_pred !== 1'b0 || btb_miss_o !== 1'b0) begin
            n_err++; $display("FAIL nt_flags: got pred=%b btb=%b expected 0/0", prev_pred, btb_miss_o);
        end
        n_cmp++;
        if (res_cnt !== 16'd1 || mis_cnt !== 16'd0) begin
            n_err++; $display("FAIL nt_cnt: got res=%0d mis=%0d expected 1/0", res_cnt, mis_cnt);
        end
        tick();
    endtask

    task automatic test_direction_mispredict();
        send(32'h200, 1'b0, 1'b1, 32'h180, 1'b0, 32'h0);
        @(negedge clk);
        n_cmp++;
        if (mispred !== 1'b1 || redirect !== 32'h180) begin
            n_err++; $display("FAIL dir_pulse: got mispred=%b redirect=%h expected 1/180", mispred, redirect);
        end
        n_cmp++;
        if (mis_cnt !== 16'd1 || pc_new !== 32'h180) begin
            n_err++; $display("FAIL dir_cnt: got mis=%0d pc_new=%h expected 1/180", mis_cnt, pc_new);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (mispred !== 1'b0 || redirect !== 32'h180) begin
            n_err++; $display("FAIL dir_width: got mispred=%b redirect=%h expected 0/180", mispred, redirect);
        end
        tick();
    endtask

    task automatic test_btb_miss();
        send(32'h300, 1'b1, 1'b1, 32'h340, 1'b1, 32'h320);
        @(negedge clk);
        n_cmp++;
        if (mispred !== 1'b1 || redirect !== 32'h340) begin
            n_err++; $display("FAIL btb_pulse: got mispred=%b redirect=%h expected 1/340", mispred, redirect);
        end
        n_cmp++;
        if (btb_miss_o !== 1'b1 || prev_pred !== 1'b1 || mis_cnt !== 16'd2) begin
            n_err++; $display("FAIL btb_upd: got btb=%b pred=%b mis=%0d expected 1/1/2", btb_miss_o, prev_pred, mis_cnt);
        end
        tick();
    endtask

    task automatic test_correct_and_wrap();
        // Correctly predicted taken branch: no pulse, redirect keeps its value.
        send(32'h400, 1'b1, 1'b1, 32'h500, 1'b1, 32'h500);
        @(negedge clk);
        n_cmp++;
        if (mispred !== 1'b0 || redirect !== 32'h340 || mis_cnt !== 16'd2) begin
            n_err++; $display("FAIL ok_pred: got mispred=%b redirect=%h mis=%0d expected 0/340/2", mispred, redirect, mis_cnt);
        end
        tick();
        // RVC fallthrough at the top of the address space wraps to 0.
        send(32'hFFFF_FFFE, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        n_cmp++;
        if (pc_new !== 32'h0 || rvi_flag !== 1'b0 || res_cnt !== 16'd5) begin
            n_err++; $display("FAIL wrap: got pc_new=%h rvi=%b res=%0d expected 0/0/5", pc_new, rvi_flag, res_cnt);
        end
        tick();
    endtask

    task automatic test_full();
        upd_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(32'h1000 + 32'(i * 4), 1'b1, 1'(i % 2), 32'h2000 + 32'(i), 1'b0, 32'h0);
        end
        @(negedge clk);
        n_cmp++;
        if (rdy !== 1'b0) begin n_err++; $display("FAIL full_rdy: got %b expected 0", rdy); end
        tick();
        // Offer a fifth branch that must not be taken while full.
        pc = 32'h1010; rvi = 1'b1; taken = 1'b0; pred = 1'b0; vd = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (rdy !== 1'b0 || upd_vd !== 1'b1 || pc_prev !== 32'h1000 || pc_new !== 32'h1004) begin
                n_err++; $display("FAIL full_hold: got rdy=%b vd=%b pc_prev=%h pc_new=%h expected 0/1/1000/1004",
                                  rdy, upd_vd, pc_prev, pc_new);
            end
            tick();
        end
        vd = 1'b0;
        upd_rdy = 1'b1;
        tick();
        @(negedge clk);
        n_cmp++;
        if (rdy !== 1'b1 || pc_prev !== 32'h1004) begin
            n_err++; $display("FAIL full_release: got rdy=%b pc_prev=%h expected 1/1004", rdy, pc_prev);
        end
        repeat (3) tick();
        @(negedge clk);
        n_cmp++;
        if (upd_vd !== 1'b0) begin n_err++; $display("FAIL full_drain: got vd=%b expected 0", upd_vd); end
        tick();
    endtask

    task automatic test_back_to_back();
        upd_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pc = 32'h5000 + 32'(i * 8); rvi = 1'(i % 3 != 0);
            taken = 1'(i % 2); pred = 1'((i / 2) % 2);
            target = 32'h6000 + 32'(i * 16); pred_tgt = target;
            vd = 1'b1;
            @(negedge clk);
            n_cmp++;
            if (rdy !== 1'b1) begin n_err++; $display("FAIL b2b_stall: cycle %0d rdy=%b expected 1", i, rdy); end
            if (i > 0) begin
                n_cmp++;
                if (upd_vd !== 1'b1 || pc_prev !== 32'h5000 + 32'((i - 1) * 8)) begin
                    n_err++; $display("FAIL b2b_head: cycle %0d vd=%b pc_prev=%h expected 1/%h",
                                      i, upd_vd, pc_prev, 32'h5000 + 32'((i - 1) * 8));
                end
            end
            tick();
        end
        vd = 1'b0;
        tick();
        @(negedge clk);
        n_cmp++;
        if (upd_vd !== 1'b0) begin n_err++; $display("FAIL b2b_occupancy: got vd=%b expected 0", upd_vd); end
        tick();
    endtask

    task automatic test_reset_mid();
        upd_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(32'h8000 + 32'(i * 4), 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        end
        // Mispredicting branch offered on the same edge that reset is sampled.
        pc = 32'h800C; rvi = 1'b1; taken = 1'b1; target = 32'h9000; pred = 1'b0;
        vd = 1'b1; rst_n = 1'b0;
        tick();
        @(negedge clk);
        n_cmp++;
        if (upd_vd !== 1'b0 || pc_prev !== 32'h0) begin
            n_err++; $display("FAIL rst_mid_fifo: got vd=%b pc_prev=%h expected 0/0", upd_vd, pc_prev);
        end
        n_cmp++;
        if (mispred !== 1'b0 || redirect !== 32'h0) begin
            n_err++; $display("FAIL rst_mid_pulse: got mispred=%b redirect=%h expected 0/0", mispred, redirect);
        end
        n_cmp++;
        if (res_cnt !== 16'd0 || mis_cnt !== 16'd0 || b_res_cnt !== 2'd0) begin
            n_err++; $display("FAIL rst_mid_cnt: got res=%0d mis=%0d sat_res=%0d expected 0", res_cnt, mis_cnt, b_res_cnt);
        end
        tick();
        vd = 1'b0; rst_n = 1'b1; upd_rdy = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (rdy !== 1'b1 || upd_vd !== 1'b0) begin
            n_err++; $display("FAIL rst_mid_release: got rdy=%b vd=%b expected 1/0", rdy, upd_vd);
        end
        tick();
    endtask

    task automatic test_saturation();
        upd_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(32'h7000 + 32'(i * 4), 1'b1, 1'b1, 32'h7100, 1'b0, 32'h0);
            @(negedge clk);
            n_cmp++;
            if (b_mis_cnt !== 2'((i + 1 > 3) ? 3 : i + 1) || mis_cnt !== 16'(i + 1)) begin
                n_err++; $display("FAIL sat_cnt: step %0d got sat_mis=%0d mis=%0d expected %0d/%0d",
                                  i, b_mis_cnt, mis_cnt, (i + 1 > 3) ? 3 : i + 1, i + 1);
            end
            tick();
        end
        @(negedge clk);
        n_cmp++;
        if (b_res_cnt !== 2'd3 || res_cnt !== 16'd5) begin
            n_err++; $display("FAIL sat_res: got sat_res=%0d res=%0d expected 3/5", b_res_cnt, res_cnt);
        end
        tick();
    endtask

    initial begin
        rst_n = 1'b0; vd = 1'b0; upd_rdy = 1'b1;
        pc = '0; rvi = 1'b0; taken = 1'b0; target = '0; pred = 1'b0; pred_tgt = '0;
        test_reset();
        test_not_taken();
        test_direction_mispredict();
        test_btb_miss();
        test_correct_and_wrap();
        test_full();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        repeat (4) tick();
        @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL sb_leftover: %0d expected records never delivered", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
